// File: rtl/comparator_search.sv
// Binary search of an unknown target through an external combinational comparator.
// Optional CMP_SEARCH_STATS_EN adds a 4-bit "steps" output counting compare cycles.
module comparator_search #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
`ifdef CMP_SEARCH_STATS_EN
    ,
    output logic [3:0]       steps
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE,
        ERR
    } state_t;

    localparam logic [WIDTH:0]          HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0]        PROBE_INIT = WIDTH'(HI_INIT >> 1);
    localparam logic signed [WIDTH+1:0] ONE        = 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [WIDTH:0]          lo;
    logic [WIDTH:0]          hi;
    logic signed [WIDTH+1:0] probe_s;
    logic signed [WIDTH+1:0] lo_s_nxt;
    logic signed [WIDTH+1:0] hi_s_nxt;
    logic [WIDTH:0]          lo_nxt;
    logic [WIDTH:0]          hi_nxt;
    logic [WIDTH:0]          mid_sum;
    logic [WIDTH-1:0]        probe_nxt;
    logic                    one_hot;
    logic                    not_found;

    // Bounds are evaluated signed and one bit wider so probe-1 at zero goes negative
    // instead of wrapping, which makes the lo'>hi' test exact at both range ends.
    always_comb begin
        one_hot  = ({less, equal, greater} == 3'b100) ||
                   ({less, equal, greater} == 3'b010) ||
                   ({less, equal, greater} == 3'b001);
        probe_s  = signed'({2'b00, probe});
        lo_s_nxt = signed'({1'b0, lo});
        hi_s_nxt = signed'({1'b0, hi});
        if (greater) begin
            lo_s_nxt = probe_s + ONE;
        end
        if (less) begin
            hi_s_nxt = probe_s - ONE;
        end
        not_found = lo_s_nxt > hi_s_nxt;
        lo_nxt    = lo_s_nxt[WIDTH:0];
        hi_nxt    = hi_s_nxt[WIDTH:0];
        mid_sum   = lo_nxt + hi_nxt;
        probe_nxt = WIDTH'(mid_sum >> 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (!one_hot) begin
                    state_nxt = ERR;
                end else if (equal) begin
                    state_nxt = DONE;
                end else if (not_found) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Probe and bounds only move on a valid, still-open step; result only on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe  <= '0;
            result <= '0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo    <= '0;
                        hi    <= HI_INIT;
                        probe <= PROBE_INIT;
                    end
                end
                COMPARE: begin
                    if (one_hot && equal) begin
                        result <= probe;
                    end else if (one_hot && !not_found) begin
                        lo    <= lo_nxt;
                        hi    <= hi_nxt;
                        probe <= probe_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CMP_SEARCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps <= '0;
        end else if (state == IDLE && start) begin
            steps <= '0;
        end else if (state == COMPARE) begin
            steps <= steps + 4'd1;
        end
    end
`endif

    assign busy  = (state == COMPARE);
    assign done  = (state == DONE);
    assign error = (state == ERR);

endmodule

// File: tb/tb_comparator_search.sv
// Directed bench for comparator_search: ideal comparator around a chosen target,
// binary-search reference model, literal pins on the model.
module tb_comparator_search;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         less;
    logic         equal;
    logic         greater;
    logic [W-1:0] probe;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] result;
`ifdef CMP_SEARCH_STATS_EN
    logic [3:0]   steps;
`endif

    int  checks = 0;
    int  errors = 0;
    int  target = 0;
    bit  bad    = 1'b0;
    int  done_cnt = 0;
    int  exp_q[$];
    bit  exp_found;
    int  model_result = 0;

    comparator_search #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .less    (less),
        .equal   (equal),
        .greater (greater),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .result  (result)
`ifdef CMP_SEARCH_STATS_EN
        ,
        .steps   (steps)
`endif
    );

    always #5 clk = ~clk;

    // External comparator: ideal around target, or an illegal two-flag pattern.
    always_comb begin
        if (bad) begin
            less    = 1'b1;
            equal   = 1'b0;
            greater = 1'b1;
        end else begin
            less    = target < int'(probe);
            equal   = target == int'(probe);
            greater = target > int'(probe);
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Plain binary search over 0..2^W-1 giving the probe sequence and outcome.
    task automatic model(input int t);
        int lo = 0;
        int hi = (1 << W) - 1;
        int p;
        exp_q.delete();
        exp_found = 1'b0;
        forever begin
            p = (lo + hi) / 2;
            exp_q.push_back(p);
            if (t == p) begin
                exp_found = 1'b1;
                break;
            end
            if (t > p) lo = p + 1;
            else       hi = p - 1;
            if (lo > hi) break;
        end
    endtask

    task automatic pin(input string name, input int t, input int lit[$], input bit found);
        model(t);
        check({name, "_len"}, exp_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < exp_q.size(); i++)
            check({name, "_p"}, exp_q[i], lit[i]);
        check({name, "_found"}, exp_found, found);
    endtask

    // Entered and left at a falling edge.
    task automatic search(input int t, input bit bad_in, input bit hold);
        int n0;
        int last;
        if (bad_in) begin
            exp_q = {3};
            exp_found = 1'b0;
        end else begin
            model(t);
        end
        target = t;
        bad    = bad_in;
        n0     = done_cnt;
        start  = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        foreach (exp_q[i]) begin
            check("busy_cmp", busy, 1);
            check("probe_seq", probe, exp_q[i]);
            check("done_early", done, 0);
            check("error_early", error, 0);
            @(negedge clk);
        end
        last = exp_q[exp_q.size()-1];
        if (exp_found) model_result = t;
        check("done_pulse", done, exp_found);
        check("error_pulse", error, !exp_found);
        check("busy_end", busy, 0);
        check("result", result, model_result);
        check("probe_hold", probe, last);
`ifdef CMP_SEARCH_STATS_EN
        check("steps", steps, exp_q.size());
`endif
        start = 1'b0;
        bad   = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("error_one_cycle", error, 0);
        check("idle_busy", busy, 0);
        check("result_held", result, model_result);
        check("probe_idle", probe, last);
        if (hold) check("single_done", done_cnt - n0, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_probe", probe, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
`ifdef CMP_SEARCH_STATS_EN
        check("rst_steps", steps, 0);
`endif
        pin("model_t4", 4, {3, 5, 4}, 1'b1);
        pin("model_t7", 7, {3, 5, 6, 7}, 1'b1);
        pin("model_t0", 0, {3, 1, 0}, 1'b1);
        pin("model_below", -1, {3, 1, 0}, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        search(4, 1'b0, 1'b0);
        search(0, 1'b0, 1'b0);
        search(7, 1'b0, 1'b0);
        search(2, 1'b1, 1'b0);
        search(-1, 1'b0, 1'b0);
        search(5, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a search.
        target = 5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_probe0", probe, 3);
        @(negedge clk);
        check("mid_probe1", probe, 5);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_probe", probe, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_done", done, 0);
`ifdef CMP_SEARCH_STATS_EN
        check("arst_steps", steps, 0);
`endif
        model_result = 0;
        @(negedge clk);
        rst = 1'b0;
        search(6, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_search.md
COMPARATOR_SEARCH -- requirements
Module: comparator_search

Interface
REQ-001 Parameter: WIDTH, 3, bit width of the searched value; it also sets the probe and result widths.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 less  input  1  external comparator flag; high when the unknown target is less than probe.
REQ-006 equal  input  1  external comparator flag; high when the target equals probe.
REQ-007 greater  input  1  external comparator flag; high when the target is greater than probe.
REQ-008 probe  output  WIDTH  registered candidate value driven to the external comparator's B operand.
REQ-009 busy  output  1  high while a search is in progress (state COMPARE).
REQ-010 done  output  1  one-cycle pulse; result is valid and found.
REQ-011 error  output  1  one-cycle pulse; search aborted.
REQ-012 result  output  WIDTH  last found target; held until the next successful search.

Function
REQ-013 The block SHALL implement states IDLE, COMPARE, DONE and ERR.
REQ-014 The block SHALL treat the comparator as purely combinational, so the flags for the current probe are valid in the same cycle.
REQ-015 IDLE with start=1 SHALL load lo=0 and hi=2^WIDTH-1, load probe=(lo+hi)>>1, and go to COMPARE.
REQ-016 COMPARE SHALL sample the flags every cycle.
- equal SHALL set result=probe and go to DONE.
- greater SHALL set lo=probe+1.
- less SHALL set hi=probe-1.
- After greater or less, the new probe SHALL be (lo'+hi')>>1 and the state SHALL stay COMPARE.
REQ-017 lo, hi and the midpoint sum SHALL be computed WIDTH+1 bits wide, so probe=0 with less and probe=max with greater do not wrap.
REQ-018 The block SHALL go to ERR, not update result, if any of the following holds:
- the updated bounds satisfy lo'>hi' (target not found);
- the flags are not exactly one-hot (none set, or two or more set).
REQ-019 DONE and ERR SHALL each last exactly one cycle, asserting done or error respectively, then return to IDLE.
REQ-020 start SHALL be ignored in COMPARE, DONE and ERR.
REQ-021 Latency from start sampled to done asserted SHALL equal the number of compare cycles, which is at most WIDTH+1.
REQ-022 probe SHALL hold its last value in IDLE, DONE and ERR.

Reset
REQ-023 rst=1 SHALL immediately force the following, from any state including mid-search:
- state=IDLE;
- probe=0, result=0, lo=0, hi=0;
- busy=0, done=0, error=0.
REQ-024 The first start SHALL be honored on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro CMP_SEARCH_STATS_EN SHALL control an extra output port "steps", 4 bits wide (valid for WIDTH<=14).
- With the macro defined, steps SHALL clear at start and increment once per COMPARE cycle.
- steps SHALL hold its final count from done/error until the next start, and SHALL reset to 0.
- Without the macro, the steps port and its counter SHALL not exist, and all other behaviour SHALL be identical.

Verification (WIDTH=3; bench models an ideal comparator around a chosen target)
REQ-026 Target 4, pulse start -> probes 3,5,4; done on the 3rd cycle after start; result=4; steps=3.
REQ-027 Target 7 -> probes 3,5,6,7; done after 4 cycles; result=7; steps=4. Target 0 -> probes 3,1,0; result=0; steps=3.
REQ-028 Force less=1 and greater=1 on the first compare -> error pulses for 1 cycle; result keeps its prior value; busy=0; state IDLE.
REQ-029 Bench comparator always returns less (target below range) -> probes 3,1,0, then error; no wrap of probe past 0.
REQ-030 Two cases:
- start held high during a search for 5 -> a single search runs, and done pulses exactly once;
- rst asserted at probe=5 mid-search -> probe=0, busy=0, result=0 immediately, and the next start restarts at probe 3.
